// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag index and buffer state definitions for the ALU result stage
package alu_pkg;

  localparam int ALU_WIDTH = 64;
  localparam int ALU_FLAG_W = 4;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } alu_op_e;

  // Occupancy of the 2-entry skid buffer; the encoding equals the entry count
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_skid_buf.sv
// rtl/alu_skid_buf.sv - generic 2-entry valid/ready skid buffer, head entry drives the output
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int PW = 68
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  buf_state_e    state_q;
  buf_state_e    state_d;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic          accept;
  logic          emit;
  logic          load_head;
  logic          load_tail;
  logic          shift;

  // in_ready depends only on the registered state, so out_ready never reaches it combinationally
  assign in_ready  = (state_q != BUF_TWO);
  assign out_valid = (state_q != BUF_EMPTY);
  assign out_data  = head_q;
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and slot write controls; head is the oldest entry, tail the second
  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_tail = 1'b0;
    shift     = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          state_d   = BUF_ONE;
          load_head = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && emit) begin
          load_head = 1'b1;
        end else if (accept) begin
          state_d   = BUF_TWO;
          load_tail = 1'b1;
        end else if (emit) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (emit) begin
          state_d = BUF_ONE;
          shift   = 1'b1;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
  end

  // Entry storage; head only changes on an accept into an empty/draining slot or a shift, so it is stable under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head) begin
        head_q <= in_data;
      end else if (shift) begin
        head_q <= tail_q;
      end
      if (load_tail) begin
        tail_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result select, NZCV flags, skid buffer and sticky overflow; option ALU_RESULT_PARITY_EN
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int FLAG_W = ALU_FLAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] and_y,
  input  logic [WIDTH-1:0] or_y,
  input  logic [WIDTH-1:0] xor_y,
  input  logic [WIDTH-1:0] sum_y,
  input  logic             sum_cout,
  input  logic             sum_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [FLAG_W-1:0] out_flags,
`ifdef ALU_RESULT_PARITY_EN
  output logic             out_parity,
`endif
  output logic             sticky_ovf,
  input  logic             ovf_clr
);

`ifdef ALU_RESULT_PARITY_EN
  localparam int PW = WIDTH + FLAG_W + 1;
`else
  localparam int PW = WIDTH + FLAG_W;
`endif

  alu_op_e          op;
  logic [WIDTH-1:0] res;
  logic [FLAG_W-1:0] flg;
  logic [PW-1:0]    buf_in;
  logic [PW-1:0]    buf_out;
  logic             accept;

  assign op     = alu_op_e'(in_op);
  assign accept = in_valid && in_ready;

  // Result select by opcode
  always_comb begin
    res = and_y;
    case (op)
      OP_AND:  res = and_y;
      OP_OR:   res = or_y;
      OP_XOR:  res = xor_y;
      OP_ADD:  res = sum_y;
      default: res = and_y;
    endcase
  end

  // Flag derivation; carry and overflow only carry meaning for the adder
  always_comb begin
    flg         = '0;
    flg[FLAG_N] = res[WIDTH-1];
    flg[FLAG_Z] = (res == '0);
    if (op == OP_ADD) begin
      flg[FLAG_C] = sum_cout;
      flg[FLAG_V] = sum_ovf;
    end
  end

`ifdef ALU_RESULT_PARITY_EN
  assign buf_in     = {^res, flg, res};
  assign out_parity = buf_out[PW-1];
`else
  assign buf_in = {flg, res};
`endif
  assign out_result = buf_out[WIDTH-1:0];
  assign out_flags  = buf_out[WIDTH+FLAG_W-1:WIDTH];

  alu_skid_buf #(
    .PW(PW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  // Sticky overflow: an accepted overflowing ADD beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (accept && (op == OP_ADD) && sum_ovf) begin
      sticky_ovf <= 1'b1;
    end else if (ovf_clr) begin
      sticky_ovf <= 1'b0;
    end
  end

endmodule
